stage_modify_fwd: RTL and testbench

- Parametrised successor to the cell-modify pipeline stage.
- Applies INC/DEC by a multi-count delta (run-length coalesced upstream) in wrap or saturate mode.
- Forwards its own last result when consecutive ops target the same cell, hiding the stale memory read.
- Valid/ready handshake on both sides with a 2-entry (output + skid) buffer; sits between the fetch-operand stage and the writeback stage.

---
 rtl/stage_modify_fwd.sv | 128 ++++++++++++
 tb/tb_stage_modify_fwd.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_modify_fwd.sv
`default_nettype none
// ==== stage_modify_fwd : INC/DEC-by-delta cell stage, same-cell forwarding, 2-entry skid output ====
// ==== Rev 1.0 ====
module stage_modify_fwd #(
  parameter int D_WIDTH     = 8,
  parameter int DELTA_WIDTH = 4,
  parameter int SATURATE    = 0,
  parameter int OPCODE_MSB  = 7,
  parameter int OP_INC      = 0,
  parameter int OP_DEC      = 1,
  parameter int OP_IN       = 2,
  parameter int OP_OUT      = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [D_WIDTH-1:0]     a_in,
  input  logic [DELTA_WIDTH-1:0] delta_in,
  input  logic [OPCODE_MSB:0]    operation_in,
  input  logic                   same_cell_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [D_WIDTH-1:0]     a,
  output logic [OPCODE_MSB:0]    operation,
  output logic                   out_valid,
  input  logic                   out_ready
);

  logic [D_WIDTH-1:0]    a_q, a_d, skid_a_q, skid_a_d, last_result_q, last_result_d;
  logic [OPCODE_MSB:0]   operation_q, operation_d, skid_op_q, skid_op_d;
  logic                  out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic                  fwd_ok_q, fwd_ok_d;

  logic                  accept;
  logic                  use_fwd;
  logic [D_WIDTH-1:0]    src;
  logic [D_WIDTH:0]      delta_ext, sum, diff;
  logic [D_WIDTH-1:0]    result;
  logic                  op_known;

  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & in_ready;
  assign a         = a_q;
  assign operation = operation_q;
  assign out_valid = out_valid_q;

  // IN always takes fresh input data, so it never consumes the forwarded value.
  always_comb begin
    use_fwd   = same_cell_in & fwd_ok_q & ~operation_in[OP_IN];
    src       = use_fwd ? last_result_q : a_in;
    delta_ext = '0;
    delta_ext[DELTA_WIDTH-1:0] = delta_in;
    sum       = {1'b0, src} + delta_ext;
    diff      = {1'b0, src} - delta_ext;
    op_known  = operation_in[OP_INC] | operation_in[OP_DEC] |
                operation_in[OP_IN]  | operation_in[OP_OUT];
    result    = '0;
    if (operation_in[OP_INC]) begin
      result = ((SATURATE != 0) && sum[D_WIDTH]) ? '1 : sum[D_WIDTH-1:0];
    end else if (operation_in[OP_DEC]) begin
      result = ((SATURATE != 0) && diff[D_WIDTH]) ? '0 : diff[D_WIDTH-1:0];
    end else if (operation_in[OP_IN]) begin
      result = a_in;
    end else if (operation_in[OP_OUT]) begin
      result = src;
    end
  end

  always_comb begin
    last_result_d = last_result_q;
    fwd_ok_d      = fwd_ok_q;
    if (accept) begin
      last_result_d = result;
      fwd_ok_d      = op_known;
    end
  end

  // Output register refills from the skid first to keep FIFO order.
  always_comb begin
    a_d          = a_q;
    operation_d  = operation_q;
    out_valid_d  = out_valid_q;
    skid_a_d     = skid_a_q;
    skid_op_d    = skid_op_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        a_d          = skid_a_q;
        operation_d  = skid_op_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          a_d         = result;
          operation_d = operation_in;
        end
      end
    end else if (accept) begin
      skid_a_d     = result;
      skid_op_d    = operation_in;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q           <= '0;
      operation_q   <= '0;
      out_valid_q   <= 1'b0;
      skid_a_q      <= '0;
      skid_op_q     <= '0;
      skid_valid_q  <= 1'b0;
      fwd_ok_q      <= 1'b0;
      last_result_q <= '0;
    end else begin
      a_q           <= a_d;
      operation_q   <= operation_d;
      out_valid_q   <= out_valid_d;
      skid_a_q      <= skid_a_d;
      skid_op_q     <= skid_op_d;
      skid_valid_q  <= skid_valid_d;
      fwd_ok_q      <= fwd_ok_d;
      last_result_q <= last_result_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage_modify_fwd.sv
`default_nettype none
// ==== tb_stage_modify_fwd : wrap and saturate instances driven in parallel against a queue model ====
// ==== Rev 1.0 ====
module tb_stage_modify_fwd;

  localparam int OP_IN = 2;
  localparam logic [7:0] INC = 8'h01, DEC = 8'h02, IN = 8'h04, OUT = 8'h08, OTH = 8'h20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] a_in = '0;
  logic [3:0] delta_in = '0;
  logic [7:0] operation_in = '0;
  logic       same_cell_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;

  wire        in_ready_w, in_ready_s, out_valid_w, out_valid_s;
  wire [7:0]  a_w, a_s, op_w, op_s;

  always #5 clk = ~clk;

  stage_modify_fwd #(.SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .a_in(a_in), .delta_in(delta_in),
    .operation_in(operation_in), .same_cell_in(same_cell_in),
    .in_valid(in_valid), .in_ready(in_ready_w), .a(a_w),
    .operation(op_w), .out_valid(out_valid_w), .out_ready(out_ready));

  stage_modify_fwd #(.SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .a_in(a_in), .delta_in(delta_in),
    .operation_in(operation_in), .same_cell_in(same_cell_in),
    .in_valid(in_valid), .in_ready(in_ready_s), .a(a_s),
    .operation(op_s), .out_valid(out_valid_s), .out_ready(out_ready));

  typedef struct {int vw; int vs; logic [7:0] op;} entry_t;
  entry_t q[$];
  int     last_w, last_s;
  bit     fwd_ok;
  int     n_checks = 0;
  int     n_fail = 0;

  function automatic int calc(int src, int ain, int delta, logic [7:0] op, bit sat);
    int r;
    if (op[0]) begin
      r = src + delta;
      if (r > 255) r = sat ? 255 : r - 256;
    end else if (op[1]) begin
      r = src - delta;
      if (r < 0) r = sat ? 0 : r + 256;
    end else if (op[2]) r = ain;
    else if (op[3])     r = src;
    else                r = 0;
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    last_w = 0;
    last_s = 0;
    fwd_ok = 1'b0;
  endtask

  // Advance the model across the coming rising edge, then land 1 time unit past it.
  task automatic tick();
    bit     acc, fire, use_fwd;
    entry_t e;
    fire = (q.size() > 0) && out_ready;
    acc  = in_valid && (q.size() < 2);
    e = '{0, 0, 8'h00};
    if (acc) begin
      use_fwd = same_cell_in && fwd_ok && !operation_in[OP_IN];
      e.vw = calc(use_fwd ? last_w : int'(a_in), int'(a_in), int'(delta_in), operation_in, 1'b0);
      e.vs = calc(use_fwd ? last_s : int'(a_in), int'(a_in), int'(delta_in), operation_in, 1'b1);
      e.op = operation_in;
      last_w = e.vw;
      last_s = e.vs;
      fwd_ok = |operation_in[3:0];
    end
    if (fire) void'(q.pop_front());
    if (acc) q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, logic [7:0] ain, logic [3:0] d, logic [7:0] op, bit same);
    in_valid     = v;
    a_in         = ain;
    delta_in     = d;
    operation_in = op;
    same_cell_in = same;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (out_valid_w !== 1'b0 || out_valid_s !== 1'b0 || in_ready_w !== 1'b1 || in_ready_s !== 1'b1 ||
        a_w !== 8'h00 || a_s !== 8'h00 || op_w !== 8'h00 || op_s !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: ov=%b/%b ir=%b/%b a=%h/%h op=%h/%h, required ov=0 ir=1 a=00 op=00",
               out_valid_w, out_valid_s, in_ready_w, in_ready_s, a_w, a_s, op_w, op_s);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    drive(1, 8'h05, 4'd1, INC, 0);
    tick();
    n_checks++;
    if (a_w !== 8'h06 || a_s !== 8'h06 || out_valid_w !== 1'b1 || op_w !== INC || op_s !== INC) begin
      n_fail++;
      $display("FAIL basic_inc: a=%h/%h ov=%b op=%h/%h, required a=06 ov=1 op=%h", a_w, a_s, out_valid_w, op_w, op_s, INC);
    end
    drive(0, 8'h00, 4'd0, 8'h00, 0);
    tick();
    n_checks++;
    if (out_valid_w !== 1'b0 || out_valid_s !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain: ov=%b/%b, required 0", out_valid_w, out_valid_s);
    end
  endtask

  task automatic test_wrap_sat();
    drive(1, 8'hFE, 4'd3, INC, 0);
    tick();
    n_checks++;
    if (a_w !== 8'h01 || a_s !== 8'hFF) begin
      n_fail++;
      $display("FAIL inc_overflow: wrap=%h sat=%h, required wrap=01 sat=FF", a_w, a_s);
    end
    drive(1, 8'h02, 4'd5, DEC, 0);
    tick();
    n_checks++;
    if (a_w !== 8'hFD || a_s !== 8'h00 || op_w !== DEC) begin
      n_fail++;
      $display("FAIL dec_underflow: wrap=%h sat=%h op=%h, required wrap=FD sat=00 op=%h", a_w, a_s, op_w, DEC);
    end
    drive(1, 8'h10, 4'd4, INC | DEC, 0);
    tick();
    n_checks++;
    if (a_w !== 8'h14 || a_s !== 8'h14) begin
      n_fail++;
      $display("FAIL inc_wins: a=%h/%h, required 14", a_w, a_s);
    end
    drive(1, 8'h33, 4'd2, OTH, 0);
    tick();
    n_checks++;
    if (a_w !== 8'h00 || a_s !== 8'h00 || op_w !== OTH) begin
      n_fail++;
      $display("FAIL other_op: a=%h/%h op=%h, required a=00 op=%h", a_w, a_s, op_w, OTH);
    end
    drive(0, 8'h00, 4'd0, 8'h00, 0);
    tick();
  endtask

  task automatic test_forward();
    drive(1, 8'h10, 4'd2, INC, 0);
    tick();
    n_checks++;
    if (a_w !== 8'h12 || a_s !== 8'h12) begin
      n_fail++;
      $display("FAIL fwd_first: a=%h/%h, required 12", a_w, a_s);
    end
    drive(1, 8'h10, 4'd3, INC, 1);
    tick();
    n_checks++;
    if (a_w !== 8'h15 || a_s !== 8'h15) begin
      n_fail++;
      $display("FAIL fwd_same_cell: a=%h/%h, required 15", a_w, a_s);
    end
    drive(1, 8'h10, 4'd2, INC, 0);
    tick();
    drive(1, 8'h10, 4'd3, INC, 0);
    tick();
    n_checks++;
    if (a_w !== 8'h13 || a_s !== 8'h13) begin
      n_fail++;
      $display("FAIL fwd_other_cell: a=%h/%h, required 13", a_w, a_s);
    end
    drive(0, 8'h00, 4'd0, 8'h00, 0);
    tick();
  endtask

  task automatic test_in_out();
    drive(1, 8'h20, 4'd1, INC, 0);
    tick();
    drive(1, 8'h41, 4'd7, IN, 1);
    tick();
    n_checks++;
    if (a_w !== 8'h41 || a_s !== 8'h41 || op_w !== IN) begin
      n_fail++;
      $display("FAIL in_no_fwd: a=%h/%h op=%h, required a=41 op=%h", a_w, a_s, op_w, IN);
    end
    drive(1, 8'h00, 4'd0, OUT, 1);
    tick();
    n_checks++;
    if (a_w !== 8'h41 || a_s !== 8'h41 || op_w !== OUT) begin
      n_fail++;
      $display("FAIL out_fwd: a=%h/%h op=%h, required a=41 op=%h", a_w, a_s, op_w, OUT);
    end
    drive(0, 8'h00, 4'd0, 8'h00, 0);
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1, 8'h30, 4'd1, INC, 0);
    tick();
    drive(1, 8'h40, 4'd1, INC, 0);
    tick();
    n_checks++;
    if (in_ready_w !== 1'b0 || a_w !== 8'h31 || out_valid_w !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: ir=%b a=%h ov=%b, required ir=0 a=31 ov=1", in_ready_w, a_w, out_valid_w);
    end
    drive(1, 8'h50, 4'd1, INC, 0);
    tick();
    n_checks++;
    if (in_ready_w !== 1'b0 || in_ready_s !== 1'b0 || a_w !== 8'h31) begin
      n_fail++;
      $display("FAIL bp_hold: ir=%b/%b a=%h, required ir=0 a=31", in_ready_w, in_ready_s, a_w);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (a_w !== 8'h41 || out_valid_w !== 1'b1 || in_ready_w !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_skid_drain: a=%h ov=%b ir=%b, required a=41 ov=1 ir=1", a_w, out_valid_w, in_ready_w);
    end
    tick();
    n_checks++;
    if (a_w !== 8'h51 || out_valid_w !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_third: a=%h ov=%b, required a=51 ov=1", a_w, out_valid_w);
    end
    drive(0, 8'h00, 4'd0, 8'h00, 0);
    tick();
    n_checks++;
    if (out_valid_w !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_dup: ov=%b, required 0", out_valid_w);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1, 8'h60, 4'd1, INC, 0);
    tick();
    drive(1, 8'h70, 4'd1, INC, 1);
    tick();
    drive(0, 8'h00, 4'd0, 8'h00, 0);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid_w !== 1'b0 || out_valid_s !== 1'b0 || in_ready_w !== 1'b1 || in_ready_s !== 1'b1 ||
        a_w !== 8'h00 || a_s !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: ov=%b/%b ir=%b/%b a=%h/%h, required ov=0 ir=1 a=00",
               out_valid_w, out_valid_s, in_ready_w, in_ready_s, a_w, a_s);
    end
    model_reset();
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1, 8'h80, 4'd1, INC, 1);
    tick();
    n_checks++;
    if (a_w !== 8'h81 || a_s !== 8'h81 || out_valid_w !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_no_fwd: a=%h/%h ov=%b, required a=81 ov=1", a_w, a_s, out_valid_w);
    end
    drive(0, 8'h00, 4'd0, 8'h00, 0);
    tick();
  endtask

  task automatic test_random();
    logic [7:0] op;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 6))
        0: op = INC;
        1: op = DEC;
        2: op = IN;
        3: op = OUT;
        4: op = OTH;
        5: op = INC | DEC;
        default: op = 8'h00;
      endcase
      drive($urandom_range(0, 3) != 0, 8'($urandom), 4'($urandom), op, 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      n_checks++;
      if (out_valid_w !== (q.size() > 0) || out_valid_s !== (q.size() > 0) ||
          in_ready_w !== (q.size() < 2) || in_ready_s !== (q.size() < 2)) begin
        n_fail++;
        $display("FAIL rand_flow[%0d]: ov=%b/%b ir=%b/%b, required ov=%b ir=%b",
                 i, out_valid_w, out_valid_s, in_ready_w, in_ready_s, q.size() > 0, q.size() < 2);
      end else if (q.size() > 0) begin
        n_checks++;
        if (int'(a_w) != q[0].vw || int'(a_s) != q[0].vs || op_w !== q[0].op || op_s !== q[0].op) begin
          n_fail++;
          $display("FAIL rand_data[%0d]: a=%h/%h op=%h/%h, required a=%h/%h op=%h",
                   i, a_w, a_s, op_w, op_s, q[0].vw, q[0].vs, q[0].op);
        end
      end
    end
    drive(0, 8'h00, 4'd0, 8'h00, 0);
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_sat();
    test_forward();
    test_in_out();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
